cis_line_capture: RTL and testbench
===================================

CIS_LINE_CAPTURE -- requirements
Module: cis_line_capture

Interface
REQ-001 Parameter PIX_CNT, default 2592: active pixels per line.
REQ-002 Parameter SKIP_CNT, default 16: leading ADC samples discarded after each SI rise.
REQ-003 Parameter FIFO_DEPTH, default 16: output FIFO depth in words, power of two.
REQ-004 CLK  in  1  system clock; all logic on rising edge.
REQ-005 RST  in  1  synchronous, active-high reset.
REQ-006 EN  in  1  capture enable, sampled only at SI rise.
REQ-007 SI  in  1  line-start pulse from the CIS controller, same clock domain.
REQ-008 SI_CNT  in  2  colour index for the line (0=R, 1=G, 2=B).
REQ-009 ADC_DATA  in  12  pixel sample.
REQ-010 ADC_VALID  in  1  one-cycle strobe marking a valid ADC_DATA.
REQ-011 CLR_ERR  in  1  one-cycle clear of the sticky error flags.
REQ-012 M_DATA  out  32  output stream word.
REQ-013 M_VALID  out  1  output word valid.
REQ-014 M_READY  in  1  downstream ready.
REQ-015 M_LAST  out  1  marks the last pixel word of a complete line.
REQ-016 LINE_CNT  out  16  number of lines started since reset.
REQ-017 ERR_OVF  out  1  sticky flag: a word was dropped because the FIFO was full.
REQ-018 ERR_SHORT  out  1  sticky flag: a line was aborted by an early SI.

Function
REQ-019 SI rise SHALL be detected as SI & ~SI_d, using one internal register.
REQ-020 FSM states SHALL be IDLE, SKIP, CAPTURE: IDLE->SKIP on SI rise with EN=1; SKIP->CAPTURE after SKIP_CNT ADC_VALID strobes; CAPTURE->IDLE after PIX_CNT strobes.
REQ-021 On an accepted SI rise, the block SHALL latch SI_CNT, increment LINE_CNT (wrapping at 16 bits) and push the header word {8'hA5, 6'b0, colour[1:0], LINE_CNT new value[15:0]} one cycle later.
REQ-022 In CAPTURE, pixels SHALL be paired in arrival order; word = {4'b0, second[11:0], 4'b0, first[11:0]}, pushed one cycle after the second pixel; PIX_CNT is required to be even.
REQ-023 The word carrying pixels PIX_CNT-2 and PIX_CNT-1 SHALL be stored with a last tag, which drives M_LAST when that word is output.
REQ-024 An SI rise in SKIP or CAPTURE SHALL abort the line: the pending half-word is discarded, ERR_SHORT is set, and a new line starts per REQ-021 if EN=1, otherwise the FSM returns to IDLE; no last tag is emitted for the aborted line.
REQ-025 An SI rise with EN=0 SHALL be ignored, and LINE_CNT SHALL not change.
REQ-026 A push while the FIFO is full SHALL drop that word, set ERR_OVF, and leave the pixel counters running.
REQ-027 The output SHALL follow valid/ready: a word transfers when M_VALID & M_READY; M_DATA and M_LAST hold while M_VALID=1 and M_READY=0.
REQ-028 A simultaneous push and pop on a full FIFO SHALL succeed without setting ERR_OVF.
REQ-029 CLR_ERR SHALL clear both flags; an error event in the same cycle wins and keeps its flag set.
REQ-030 ADC_VALID in IDLE SHALL be ignored.

Reset
REQ-031 RST SHALL set the FSM to IDLE, empty the FIFO, and clear the following outputs: M_VALID=0, M_LAST=0, LINE_CNT=0, ERR_OVF=0, ERR_SHORT=0.
REQ-032 RST asserted mid-line SHALL discard all buffered words; the next line begins only on a fresh SI rise.

Structure
REQ-033 The header marker 8'hA5, the FSM state encoding and the default parameter values SHALL live in the shared package cis_pkg.
REQ-034 The FIFO SHALL be a separate sub-module, sync_fifo, 33 bits wide (data plus last tag), with full/empty flags.

Verification
REQ-035 EN=1, SI pulse, SI_CNT=1, 2608 ADC strobes, M_READY=1 -> header 32'hA5010001, then 1296 pixel words, M_LAST only on the final one, LINE_CNT=1.
REQ-036 Ramp data 0,1,2,... after the skip -> first pixel word 32'h00010000, last pixel word 32'h0A1F0A1E.
REQ-037 Second SI after 100 active pixels -> ERR_SHORT=1, no M_LAST, new header with LINE_CNT=2, full line then follows.
REQ-038 M_READY=0 for a whole line -> 16 words held, ERR_OVF=1, and the first held word is the header, unchanged.
REQ-039 SI with EN=0 -> no output, LINE_CNT unchanged; CLR_ERR together with an overflow event -> ERR_OVF stays 1.
REQ-040 RST at pixel 500 -> M_VALID=0 next cycle, LINE_CNT=0, and the ADC strobes that follow produce no output until the next SI.

Source files
------------

// File: rtl/cis_pkg.sv
// Shared definitions for the CIS line capture block: defaults, FSM encoding,
// header marker and word-packing helpers.
package cis_pkg;

  localparam int PIX_CNT_DEF    = 2592;
  localparam int SKIP_CNT_DEF   = 16;
  localparam int FIFO_DEPTH_DEF = 16;

  localparam logic [7:0] HDR_MARK = 8'hA5;
  localparam int         WORD_W   = 32;
  localparam int         ENTRY_W  = WORD_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    CAPTURE = 2'd2
  } cap_state_t;

  function automatic logic [WORD_W-1:0] pack_header(input logic [1:0]  colour,
                                                    input logic [15:0] line);
    return {HDR_MARK, 6'b0, colour, line};
  endfunction

  function automatic logic [WORD_W-1:0] pack_pixels(input logic [11:0] first,
                                                    input logic [11:0] second);
    return {4'b0, second, 4'b0, first};
  endfunction

endpackage

// File: rtl/cis_line_capture_if.sv
// Output word stream of the line capture block: valid/ready with a last tag.
interface cis_line_capture_if;

  logic [31:0] M_DATA;
  logic        M_VALID;
  logic        M_READY;
  logic        M_LAST;

  modport master (output M_DATA, output M_VALID, output M_LAST, input M_READY);
  modport slave  (input M_DATA, input M_VALID, input M_LAST, output M_READY);

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; a write on a full FIFO is accepted
// only when a read happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = cis_pkg::ENTRY_W,
  parameter int DEPTH = cis_pkg::FIFO_DEPTH_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_rd;
  logic             do_wr;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_en & (~full | do_rd);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (do_wr) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/cis_line_capture.sv
// Captures CIS sensor lines: skips leading ADC samples, packs pixel pairs into
// 32-bit words behind a per-line header, and streams them through a FIFO.
module cis_line_capture
  import cis_pkg::*;
#(
  parameter int PIX_CNT    = PIX_CNT_DEF,
  parameter int SKIP_CNT   = SKIP_CNT_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic        SI,
  input  logic [1:0]  SI_CNT,
  input  logic [11:0] ADC_DATA,
  input  logic        ADC_VALID,
  input  logic        CLR_ERR,
  output logic [15:0] LINE_CNT,
  output logic        ERR_OVF,
  output logic        ERR_SHORT,
  cis_line_capture_if.master stream
);

  cap_state_t state;
  logic       si_d;
  logic       si_rise;
  logic [15:0] skip_cnt;
  logic [15:0] pix_cnt;
  logic [11:0] first;
  logic        half;
  logic [1:0]  colour;
  logic        push_hdr;
  logic        push_pix;
  logic [ENTRY_W-1:0] pix_entry;

  logic               fifo_wr;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;

  assign si_rise = SI & ~si_d;

  // The header is built from the registered colour and count one cycle after
  // the SI rise; an SI rise always beats a pixel, so both pushes never collide.
  assign fifo_wr    = push_hdr | push_pix;
  assign fifo_wdata = push_hdr ? {1'b0, pack_header(colour, LINE_CNT)} : pix_entry;
  assign pop        = stream.M_VALID & stream.M_READY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      si_d      <= 1'b0;
      skip_cnt  <= '0;
      pix_cnt   <= '0;
      first     <= '0;
      half      <= 1'b0;
      colour    <= '0;
      LINE_CNT  <= '0;
      ERR_SHORT <= 1'b0;
      push_hdr  <= 1'b0;
      push_pix  <= 1'b0;
      pix_entry <= '0;
    end else begin
      si_d      <= SI;
      push_hdr  <= 1'b0;
      push_pix  <= 1'b0;
      ERR_SHORT <= (ERR_SHORT & ~CLR_ERR) | (si_rise & (state != IDLE));
      if (si_rise) begin
        half     <= 1'b0;
        skip_cnt <= '0;
        pix_cnt  <= '0;
        if (EN) begin
          colour   <= SI_CNT;
          LINE_CNT <= LINE_CNT + 16'd1;
          push_hdr <= 1'b1;
          state    <= (SKIP_CNT == 0) ? CAPTURE : SKIP;
        end else begin
          state <= IDLE;
        end
      end else if (ADC_VALID) begin
        case (state)
          SKIP: begin
            if (skip_cnt == 16'(SKIP_CNT - 1)) begin
              skip_cnt <= '0;
              state    <= CAPTURE;
            end else begin
              skip_cnt <= skip_cnt + 16'd1;
            end
          end
          CAPTURE: begin
            if (!half) begin
              first <= ADC_DATA;
              half  <= 1'b1;
            end else begin
              half      <= 1'b0;
              push_pix  <= 1'b1;
              pix_entry <= {(pix_cnt == 16'(PIX_CNT - 1)), pack_pixels(first, ADC_DATA)};
            end
            if (pix_cnt == 16'(PIX_CNT - 1)) begin
              pix_cnt <= '0;
              state   <= IDLE;
            end else begin
              pix_cnt <= pix_cnt + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // A dropped word wins over a same-cycle clear.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ERR_OVF <= 1'b0;
    end else begin
      ERR_OVF <= (ERR_OVF & ~CLR_ERR) | (fifo_wr & fifo_full & ~pop);
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RST     (RST),
    .wr_en   (fifo_wr),
    .wr_data (fifo_wdata),
    .rd_en   (stream.M_READY),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign stream.M_VALID = ~fifo_empty;
  assign stream.M_DATA  = fifo_rdata[WORD_W-1:0];
  assign stream.M_LAST  = fifo_rdata[WORD_W] & ~fifo_empty;

endmodule

// File: tb/tb_cis_line_capture.sv
// Self-checking bench for cis_line_capture: line table plus hand-written
// overflow, clear-collision and mid-line reset sequences.
module tb_cis_line_capture;

  localparam int PIX   = 2592;
  localparam int SKIP  = 16;
  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN = 1'b0;
  logic        SI = 1'b0;
  logic [1:0]  SI_CNT = '0;
  logic [11:0] ADC_DATA = '0;
  logic        ADC_VALID = 1'b0;
  logic        CLR_ERR = 1'b0;
  logic [15:0] LINE_CNT;
  logic        ERR_OVF;
  logic        ERR_SHORT;

  cis_line_capture_if stream_if ();

  cis_line_capture #(
    .PIX_CNT    (PIX),
    .SKIP_CNT   (SKIP),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .SI        (SI),
    .SI_CNT    (SI_CNT),
    .ADC_DATA  (ADC_DATA),
    .ADC_VALID (ADC_VALID),
    .CLR_ERR   (CLR_ERR),
    .LINE_CNT  (LINE_CNT),
    .ERR_OVF   (ERR_OVF),
    .ERR_SHORT (ERR_SHORT),
    .stream    (stream_if)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        en;
    logic [1:0]  colour;
    int          nskip;
    int          npix;
    logic [15:0] exp_line;
    logic        exp_short;
  } vec_t;

  vec_t        vecs [7];
  logic [32:0] exp_q [$];
  int          checks = 0;
  int          errors = 0;
  int          model_line = 0;
  int          unexpected_seen = 0;

  task automatic checkOutput(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Every cycle passes through here: sample the stream mid-cycle, then step
  // to just after the next rising edge.
  task automatic tick();
    logic [32:0] got;
    logic [32:0] want;
    @(negedge CLK);
    if (stream_if.M_VALID === 1'b1 && stream_if.M_READY === 1'b1) begin
      got = {stream_if.M_LAST, stream_if.M_DATA};
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        unexpected_seen++;
        $display("[TB] FAIL stream_unexpected: got %h, expected no word", got);
      end else begin
        want = exp_q.pop_front();
        checkOutput("stream_word", got, want);
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic startLine(input logic en, input logic [1:0] col);
    EN     = en;
    SI_CNT = col;
    SI     = 1'b1;
    tick();
    SI = 1'b0;
    tick();
    if (en) begin
      model_line++;
      exp_q.push_back({1'b0, 8'hA5, 6'b0, col, 16'(model_line)});
    end
  endtask

  task automatic strobe(input logic [11:0] d);
    ADC_VALID = 1'b1;
    ADC_DATA  = d;
    tick();
    ADC_VALID = 1'b0;
  endtask

  task automatic driveSkip(input int n);
    for (int i = 0; i < n; i++) begin
      strobe(12'h800 | 12'(i));
      tick();
    end
  endtask

  // Ramp pixels; words with pair index below keep are expected on the stream.
  task automatic drivePixels(input int start, input int count, input int keep);
    logic [11:0] a;
    logic [11:0] b;
    for (int p = start; p < start + count; p++) begin
      strobe(12'(p));
      tick();
      if (p % 2 == 1 && (p / 2) < keep) begin
        a = 12'(p - 1);
        b = 12'(p);
        exp_q.push_back({(p == PIX - 1), 4'b0, b, 4'b0, a});
      end
    end
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 8000 && exp_q.size() != 0; i++) begin
      tick();
    end
    checkOutput(name, 33'(exp_q.size()), 33'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    startLine(v.en, v.colour);
    driveSkip(v.nskip);
    drivePixels(0, v.npix, v.en ? PIX : 0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'd1, SKIP, PIX, 16'd1, 1'b0};
    vecs[1] = '{1'b1, 2'd2, SKIP, 101, 16'd2, 1'b0};
    vecs[2] = '{1'b1, 2'd0, SKIP, PIX, 16'd3, 1'b1};
    vecs[3] = '{1'b0, 2'd2, SKIP, 40,  16'd3, 1'b0};
    vecs[4] = '{1'b1, 2'd3, 5,    0,   16'd4, 1'b0};
    vecs[5] = '{1'b1, 2'd2, SKIP, PIX, 16'd5, 1'b1};
    vecs[6] = '{1'b0, 2'd0, 3,    0,   16'd5, 1'b0};

    stream_if.M_READY = 1'b0;
    RST = 1'b1;
    repeat (3) tick();
    RST = 1'b0;
    checkOutput("reset_valid", 33'(stream_if.M_VALID), 33'd0);
    checkOutput("reset_last", 33'(stream_if.M_LAST), 33'd0);
    checkOutput("reset_line_cnt", 33'(LINE_CNT), 33'd0);
    checkOutput("reset_err_ovf", 33'(ERR_OVF), 33'd0);
    checkOutput("reset_err_short", 33'(ERR_SHORT), 33'd0);

    stream_if.M_READY = 1'b1;
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      waitDrain("line_drain");
      repeat (4) tick();
      checkOutput("line_cnt", 33'(LINE_CNT), 33'(vecs[i].exp_line));
      checkOutput("err_short", 33'(ERR_SHORT), 33'(vecs[i].exp_short));
      checkOutput("err_ovf_clean", 33'(ERR_OVF), 33'd0);
      CLR_ERR = 1'b1;
      tick();
      CLR_ERR = 1'b0;
      checkOutput("err_short_cleared", 33'(ERR_SHORT), 33'd0);
    end

    // Stalled output: header plus 15 pixel words fit, the rest are dropped.
    stream_if.M_READY = 1'b0;
    startLine(1'b1, 2'd0);
    driveSkip(SKIP);
    drivePixels(0, 40, DEPTH - 1);
    repeat (3) tick();
    checkOutput("stall_valid", 33'(stream_if.M_VALID), 33'd1);
    checkOutput("stall_head", {stream_if.M_LAST, stream_if.M_DATA}, {1'b0, 32'hA5000006});
    checkOutput("stall_err_ovf", 33'(ERR_OVF), 33'd1);
    repeat (5) tick();
    checkOutput("stall_head_hold", {stream_if.M_LAST, stream_if.M_DATA}, {1'b0, 32'hA5000006});
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    checkOutput("ovf_cleared", 33'(ERR_OVF), 33'd0);

    strobe(12'd40);
    tick();
    strobe(12'd41);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    checkOutput("ovf_beats_clear", 33'(ERR_OVF), 33'd1);
    CLR_ERR = 1'b1;
    tick();
    CLR_ERR = 1'b0;
    checkOutput("ovf_cleared_again", 33'(ERR_OVF), 33'd0);

    strobe(12'd42);
    tick();
    strobe(12'd43);
    stream_if.M_READY = 1'b1;
    tick();
    stream_if.M_READY = 1'b0;
    exp_q.push_back({1'b0, 32'h002B002A});
    tick();
    checkOutput("full_push_pop_no_ovf", 33'(ERR_OVF), 33'd0);
    checkOutput("full_push_pop_head", {stream_if.M_LAST, stream_if.M_DATA}, {1'b0, 32'h00010000});
    stream_if.M_READY = 1'b1;
    waitDrain("stall_drain");
    checkOutput("stall_line_cnt", 33'(LINE_CNT), 33'd6);

    // Mid-line reset with words still buffered.
    stream_if.M_READY = 1'b0;
    startLine(1'b1, 2'd1);
    driveSkip(SKIP);
    drivePixels(0, 500, 0);
    exp_q.delete();
    checkOutput("pre_reset_valid", 33'(stream_if.M_VALID), 33'd1);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    model_line = 0;
    checkOutput("rst_valid", 33'(stream_if.M_VALID), 33'd0);
    checkOutput("rst_line_cnt", 33'(LINE_CNT), 33'd0);
    checkOutput("rst_err_ovf", 33'(ERR_OVF), 33'd0);
    checkOutput("rst_err_short", 33'(ERR_SHORT), 33'd0);
    stream_if.M_READY = 1'b1;
    unexpected_seen = 0;
    drivePixels(500, 100, 0);
    repeat (4) tick();
    checkOutput("post_rst_no_output", 33'(unexpected_seen), 33'd0);
    checkOutput("post_rst_valid", 33'(stream_if.M_VALID), 33'd0);
    checkOutput("post_rst_line_cnt", 33'(LINE_CNT), 33'd0);

    startLine(1'b1, 2'd1);
    driveSkip(SKIP);
    drivePixels(0, PIX, PIX);
    waitDrain("post_rst_drain");
    checkOutput("post_rst_line1", 33'(LINE_CNT), 33'd1);
    checkOutput("post_rst_short", 33'(ERR_SHORT), 33'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
